// File: rtl/bus_map_pkg.sv
// Shared address-map constants and region type for the data-side bus responder.
package bus_map_pkg;

  localparam logic [3:0] OFS_OUT_DATA = 4'h0;
  localparam logic [3:0] OFS_STATUS   = 4'h4;
  localparam logic [3:0] OFS_CYCLE    = 4'h8;
  localparam logic [3:0] OFS_DROP     = 4'hC;

  localparam int unsigned STATUS_FULL_BIT  = 0;
  localparam int unsigned STATUS_EMPTY_BIT = 1;
  localparam int unsigned STATUS_COUNT_LSB = 8;
  localparam int unsigned STATUS_COUNT_MSB = 15;

  typedef enum logic [1:0] {
    REG_RAM,
    REG_MMIO,
    REG_NONE
  } region_t;

endpackage

// File: rtl/byte_fifo.sv
// Circular byte FIFO with registered head; a same-edge pop frees room for a push when full.
module byte_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            push_en, pop_en;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign count   = count_q;
  assign pop_en  = pop & ~empty;
  assign push_en = push & (~full | pop_en);
  assign head    = empty ? 8'h00 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_en, pop_en})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; head is masked while empty.
  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder: word RAM plus MMIO window (byte output FIFO, cycle and drop counters).
module data_bus_responder
  import bus_map_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [31:0] dataAddr,
  input  logic [31:0] writeData,
  input  logic        we,
  output logic [31:0] readData,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam int unsigned AddrW = $clog2(RAM_WORDS);
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram_q [RAM_WORDS];
  logic [AddrW-1:0] ram_idx;
  logic [3:0]       mmio_ofs;
  region_t          region;

  logic [31:0] cycle_q, cycle_d;
  logic [31:0] drop_q, drop_d;

  logic            wr_ram, wr_out, wr_cycle, wr_drop;
  logic            fifo_pop, fifo_empty, fifo_full, drop_evt;
  logic [7:0]      fifo_head;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     status;
  logic            unused_addr_bits;

  assign unused_addr_bits = ^dataAddr[1:0];
  assign ram_idx  = dataAddr[AddrW+1:2];
  assign mmio_ofs = {dataAddr[3:2], 2'b00};

  always_comb begin
    region = REG_NONE;
    if (dataAddr < 32'(RAM_WORDS * 4))           region = REG_RAM;
    else if (dataAddr[31:4] == MMIO_BASE[31:4])  region = REG_MMIO;
  end

  assign wr_ram   = we && (region == REG_RAM);
  assign wr_out   = we && (region == REG_MMIO) && (mmio_ofs == OFS_OUT_DATA);
  assign wr_cycle = we && (region == REG_MMIO) && (mmio_ofs == OFS_CYCLE);
  assign wr_drop  = we && (region == REG_MMIO) && (mmio_ofs == OFS_DROP);

  assign fifo_pop = out_valid & out_ready;
  assign drop_evt = wr_out & fifo_full & ~fifo_pop;

  byte_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .n_reset  (n_reset),
    .push     (wr_out),
    .push_data(writeData[7:0]),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (fifo_count)
  );

  assign out_data  = fifo_head;
  assign out_valid = ~fifo_empty;

  always_comb begin
    cycle_d = wr_cycle ? writeData : cycle_q + 32'd1;
    drop_d  = drop_q;
    if (wr_drop)                              drop_d = '0;
    else if (drop_evt && (drop_q != '1))      drop_d = drop_q + 32'd1;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cycle_q <= '0;
      drop_q  <= '0;
    end else begin
      cycle_q <= cycle_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ram) ram_q[ram_idx] <= writeData;
  end

  always_comb begin
    status = '0;
    status[STATUS_FULL_BIT]  = fifo_full;
    status[STATUS_EMPTY_BIT] = fifo_empty;
    status[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 8'(fifo_count);
  end

  always_comb begin
    readData = '0;
    unique case (region)
      REG_RAM:  readData = ram_q[ram_idx];
      REG_MMIO: begin
        unique case (mmio_ofs)
          OFS_STATUS: readData = status;
          OFS_CYCLE:  readData = cycle_q;
          OFS_DROP:   readData = drop_q;
          default:    readData = '0;
        endcase
      end
      default:  readData = '0;
    endcase
  end

endmodule
